// File: rtl/klt_integrator_param.sv
// KLT structure-tensor integrator: a three-stage pipeline (capture, gradient, product)
// feeding five signed accumulators, with result hand-off through a valid/ready handshake.
module klt_integrator_param #(
  parameter int PIX_W = 8,
  parameter int ACC_W = 26,
  parameter int CNT_W = 16,
  parameter int SAT   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    first_frame,
  input  logic                    end_of_frame,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    s_last,
  input  logic [PIX_W-1:0]        prev_center_pixel,
  input  logic [PIX_W-1:0]        center_pixel,
  input  logic [PIX_W-1:0]        left_pixel,
  input  logic [PIX_W-1:0]        right_pixel,
  input  logic [PIX_W-1:0]        up_pixel,
  input  logic [PIX_W-1:0]        down_pixel,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [ACC_W-1:0] G11,
  output logic signed [ACC_W-1:0] G12,
  output logic signed [ACC_W-1:0] G21,
  output logic signed [ACC_W-1:0] G22,
  output logic signed [ACC_W-1:0] b1,
  output logic signed [ACC_W-1:0] b2,
  output logic [CNT_W-1:0]        count,
  output logic                    ovf
);

  localparam int D_W = PIX_W + 1;
  localparam int P_W = 2 * PIX_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  function automatic logic [D_W-1:0] pix_diff(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  function automatic logic signed [P_W-1:0] sext(input logic signed [D_W-1:0] x);
    return {{(P_W-D_W){x[D_W-1]}}, x};
  endfunction

  // Returns {overflow, new_sum}; the extra sum bit exposes signed overflow.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a, input logic [P_W-1:0] p);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {{(ACC_W+1-P_W){p[P_W-1]}}, p};
    if (s[ACC_W] == s[ACC_W-1]) begin
      return {1'b0, s[ACC_W-1:0]};
    end else if (SAT != 0) begin
      return s[ACC_W] ? {1'b1, 1'b1, {(ACC_W-1){1'b0}}} : {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      return {1'b1, s[ACC_W-1:0]};
    end
  endfunction

  state_t                  state_q;
  logic [2:0]              v_q;
  logic [2:0]              last_q;
  logic [PIX_W-1:0]        pix_q [6];
  logic signed [D_W-1:0]   d_q   [3];
  logic signed [P_W-1:0]   p_q   [5];
  logic signed [ACC_W-1:0] acc_q [5];
  logic signed [ACC_W-1:0] acc_d [5];
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;
  logic                    ovf_q;
  logic                    acc_ovf_s;
  logic                    m_valid_q;
  logic                    accept_s;
  logic [ACC_W:0]          sum_s;

  assign s_ready  = rst_n && ((state_q == IDLE) || (state_q == ACCUM));
  assign accept_s = s_valid && s_ready && !first_frame && !end_of_frame;

  // Stage-3 candidate sums and saturating sample count.
  always_comb begin
    acc_ovf_s = 1'b0;
    sum_s     = {(ACC_W+1){1'b0}};
    for (int i = 0; i < 5; i++) begin
      sum_s     = acc_add(acc_q[i], p_q[i]);
      acc_d[i]  = sum_s[ACC_W-1:0];
      acc_ovf_s = acc_ovf_s | sum_s[ACC_W];
    end
    if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Pipeline, accumulators and FSM; reset and abort share the same clearing path.
  always_ff @(posedge clk) begin
    if (!rst_n || end_of_frame) begin
      state_q   <= IDLE;
      v_q       <= 3'b000;
      last_q    <= 3'b000;
      m_valid_q <= 1'b0;
      cnt_q     <= CNT_ZERO;
      ovf_q     <= 1'b0;
      for (int i = 0; i < 5; i++) acc_q[i] <= ACC_ZERO;
    end else begin
      v_q    <= {v_q[1:0], accept_s};
      last_q <= {last_q[1:0], s_last};
      pix_q[0] <= prev_center_pixel;
      pix_q[1] <= center_pixel;
      pix_q[2] <= left_pixel;
      pix_q[3] <= right_pixel;
      pix_q[4] <= up_pixel;
      pix_q[5] <= down_pixel;
      d_q[0] <= pix_diff(pix_q[3], pix_q[2]);
      d_q[1] <= pix_diff(pix_q[5], pix_q[4]);
      d_q[2] <= pix_diff(pix_q[0], pix_q[1]);
      p_q[0] <= sext(d_q[0]) * sext(d_q[0]);
      p_q[1] <= sext(d_q[0]) * sext(d_q[1]);
      p_q[2] <= sext(d_q[1]) * sext(d_q[1]);
      p_q[3] <= sext(d_q[2]) * sext(d_q[0]);
      p_q[4] <= sext(d_q[2]) * sext(d_q[1]);
      if (v_q[2]) begin
        for (int i = 0; i < 5; i++) acc_q[i] <= acc_d[i];
        cnt_q <= cnt_d;
        ovf_q <= ovf_q | acc_ovf_s | (cnt_d == CNT_MAX);
      end
      case (state_q)
        IDLE: begin
          if (accept_s) state_q <= s_last ? DRAIN : ACCUM;
        end
        ACCUM: begin
          if (accept_s && s_last) state_q <= DRAIN;
        end
        DRAIN: begin
          if (v_q[2] && last_q[2]) begin
            state_q   <= DONE;
            m_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (m_ready) begin
            state_q   <= IDLE;
            m_valid_q <= 1'b0;
            cnt_q     <= CNT_ZERO;
            ovf_q     <= 1'b0;
            for (int i = 0; i < 5; i++) acc_q[i] <= ACC_ZERO;
          end
        end
        default: begin
          state_q   <= IDLE;
          m_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign G11     = acc_q[0];
  assign G12     = acc_q[1];
  assign G21     = acc_q[1];
  assign G22     = acc_q[2];
  assign b1      = acc_q[3];
  assign b2      = acc_q[4];
  assign count   = cnt_q;
  assign ovf     = ovf_q;
  assign m_valid = m_valid_q;

endmodule

// File: tb/tb_klt_integrator_param.sv
// Bench for klt_integrator_param: three instances (default, 18-bit saturating, 18-bit wrapping)
// share one stimulus stream and are checked against a sample-list reference model.
module tb_klt_integrator_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic first_frame = 1'b0;
  logic end_of_frame = 1'b0;
  logic s_valid = 1'b0;
  logic s_last = 1'b0;
  logic m_ready = 1'b0;
  logic [7:0] px [6];
  logic signed [25:0] ga [6];
  logic signed [17:0] gb [6];
  logic signed [17:0] gc [6];
  logic [15:0] cnt [3];
  logic ov [3];
  logic mv [3];
  logic sr [3];

  int tests = 0;
  int fails = 0;
  int ixq [$];
  int iyq [$];
  int diq [$];
  longint exp_g [3][6];
  bit exp_ovf [3];
  longint exp_cnt;

  always #5 clk = ~clk;

  klt_integrator_param #(.PIX_W(8), .ACC_W(26), .CNT_W(16), .SAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .first_frame(first_frame), .end_of_frame(end_of_frame),
    .s_valid(s_valid), .s_ready(sr[0]), .s_last(s_last),
    .prev_center_pixel(px[0]), .center_pixel(px[1]), .left_pixel(px[2]),
    .right_pixel(px[3]), .up_pixel(px[4]), .down_pixel(px[5]),
    .m_valid(mv[0]), .m_ready(m_ready),
    .G11(ga[0]), .G12(ga[1]), .G21(ga[2]), .G22(ga[3]), .b1(ga[4]), .b2(ga[5]),
    .count(cnt[0]), .ovf(ov[0]));

  klt_integrator_param #(.PIX_W(8), .ACC_W(18), .CNT_W(16), .SAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .first_frame(first_frame), .end_of_frame(end_of_frame),
    .s_valid(s_valid), .s_ready(sr[1]), .s_last(s_last),
    .prev_center_pixel(px[0]), .center_pixel(px[1]), .left_pixel(px[2]),
    .right_pixel(px[3]), .up_pixel(px[4]), .down_pixel(px[5]),
    .m_valid(mv[1]), .m_ready(m_ready),
    .G11(gb[0]), .G12(gb[1]), .G21(gb[2]), .G22(gb[3]), .b1(gb[4]), .b2(gb[5]),
    .count(cnt[1]), .ovf(ov[1]));

  klt_integrator_param #(.PIX_W(8), .ACC_W(18), .CNT_W(16), .SAT(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .first_frame(first_frame), .end_of_frame(end_of_frame),
    .s_valid(s_valid), .s_ready(sr[2]), .s_last(s_last),
    .prev_center_pixel(px[0]), .center_pixel(px[1]), .left_pixel(px[2]),
    .right_pixel(px[3]), .up_pixel(px[4]), .down_pixel(px[5]),
    .m_valid(mv[2]), .m_ready(m_ready),
    .G11(gc[0]), .G12(gc[1]), .G21(gc[2]), .G22(gc[3]), .b1(gc[4]), .b2(gc[5]),
    .count(cnt[2]), .ovf(ov[2]));

  task automatic chk(input string tag, input logic signed [63:0] o, input logic signed [63:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  function automatic logic signed [63:0] obs_g(input int k, input int i);
    case (k)
      0:       return 64'(ga[i]);
      1:       return 64'(gb[i]);
      default: return 64'(gc[i]);
    endcase
  endfunction

  // One accumulation step of the reference: exact sum, then clamp or wrap into w bits.
  function automatic longint madd(input longint a, input longint p, input int w, input bit sat, output bit o);
    longint s, lim;
    lim = longint'(1) << (w - 1);
    s = a + p;
    o = 1'b0;
    if (s >= lim || s < -lim) begin
      o = 1'b1;
      if (sat) s = (s >= lim) ? lim - 1 : -lim;
      else     s = (s >= lim) ? s - 2 * lim : s + 2 * lim;
    end
    return s;
  endfunction

  task automatic compute_model();
    longint a [5];
    longint p [5];
    bit o;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 5; i++) a[i] = 0;
      exp_ovf[k] = 1'b0;
      foreach (ixq[j]) begin
        p[0] = ixq[j] * ixq[j];
        p[1] = ixq[j] * iyq[j];
        p[2] = iyq[j] * iyq[j];
        p[3] = diq[j] * ixq[j];
        p[4] = diq[j] * iyq[j];
        for (int i = 0; i < 5; i++) begin
          a[i] = madd(a[i], p[i], (k == 0) ? 26 : 18, (k == 1), o);
          exp_ovf[k] = exp_ovf[k] | o;
        end
      end
      exp_g[k][0] = a[0]; exp_g[k][1] = a[1]; exp_g[k][2] = a[1];
      exp_g[k][3] = a[2]; exp_g[k][4] = a[3]; exp_g[k][5] = a[4];
    end
    exp_cnt = ixq.size();
  endtask

  task automatic clear_model();
    ixq.delete(); iyq.delete(); diq.delete();
    compute_model();
  endtask

  task automatic check_all(input string tag, input bit exp_mv);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 6; i++)
        chk($sformatf("%s.d%0d.g%0d", tag, k, i), obs_g(k, i), exp_g[k][i]);
      chk($sformatf("%s.d%0d.count", tag, k), cnt[k], exp_cnt);
      chk($sformatf("%s.d%0d.ovf", tag, k), ov[k], exp_ovf[k]);
      chk($sformatf("%s.d%0d.m_valid", tag, k), mv[k], exp_mv);
    end
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int r, input int l, input int d, input int u, input int p, input int c,
                      input bit last, input bit ff);
    px[0] = 8'(p); px[1] = 8'(c); px[2] = 8'(l); px[3] = 8'(r); px[4] = 8'(u); px[5] = 8'(d);
    s_last = last; first_frame = ff; s_valid = 1'b1;
    chk("s_ready.send", sr[0], 1);
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0; first_frame = 1'b0;
    if (!ff) begin
      ixq.push_back(r - l); iyq.push_back(d - u); diq.push_back(p - c);
    end
  endtask

  task automatic rand_send(input bit last, input bit ff);
    send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
         $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), last, ff);
  endtask

  // Call right after the edge that accepted the last sample.
  task automatic wait_result(input bit early_ready);
    int n;
    m_ready = early_ready;
    compute_model();
    n = 0;
    while (mv[0] !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("latency", n, 3);
    check_all("result", 1'b1);
  endtask

  task automatic handshake(input int hold);
    for (int c = 0; c < hold; c++) begin
      px[0] = 8'($urandom); px[3] = 8'($urandom);
      s_last = 1'($urandom); s_valid = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) chk($sformatf("hold.d%0d.s_ready", k), sr[k], 0);
      check_all("hold", 1'b1);
    end
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    clear_model();
    check_all("cleared", 1'b0);
    chk("s_ready.after", sr[0], 1);
  endtask

  initial begin
    for (int i = 0; i < 6; i++) px[i] = 8'd0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("reset.d%0d.s_ready", k), sr[k], 0);
    check_all("reset", 1'b0);
    rst_n = 1'b1;
    idle(1);

    send(10, 4, 7, 1, 50, 40, 1'b1, 1'b0);
    wait_result(1'b0);
    chk("single.G11", ga[0], 36); chk("single.G21", ga[2], 36);
    chk("single.b1", ga[4], 60);  chk("single.count", cnt[0], 1);
    handshake(0);

    send(0, 200, 0, 0, 0, 100, 1'b0, 1'b0);
    send(0, 200, 0, 0, 0, 100, 1'b1, 1'b0);
    wait_result(1'b0);
    chk("neg.G11", ga[0], 80000); chk("neg.b1", ga[4], 40000); chk("neg.count", cnt[0], 2);
    handshake(10);

    send(255, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    send(255, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    send(255, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    wait_result(1'b0);
    chk("ovf.sat.G11", gb[0], 131071); chk("ovf.sat.flag", ov[1], 1);
    chk("ovf.wrap.G11", gc[0], -67069); chk("ovf.wrap.flag", ov[2], 1);
    handshake(2);

    send(9, 1, 5, 2, 30, 3, 1'b0, 1'b1);
    send(9, 1, 5, 2, 30, 3, 1'b1, 1'b1);
    idle(5);
    check_all("first_frame", 1'b0);

    send(20, 3, 8, 1, 60, 10, 1'b1, 1'b0);
    end_of_frame = 1'b1;
    @(posedge clk); #1;
    end_of_frame = 1'b0;
    clear_model();
    for (int c = 0; c < 6; c++) begin @(posedge clk); #1; chk("eof_drain.m_valid", mv[0], 0); end
    check_all("eof_drain", 1'b0);

    px[3] = 8'd100; px[2] = 8'd0; s_last = 1'b1; s_valid = 1'b1; end_of_frame = 1'b1;
    @(posedge clk); #1;
    end_of_frame = 1'b0; s_last = 1'b0;
    idle(5);
    check_all("eof_sample", 1'b0);

    rand_send(1'b0, 1'b0);
    rand_send(1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("rst_accum.d%0d.s_ready", k), sr[k], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_model();
    for (int c = 0; c < 5; c++) begin @(posedge clk); #1; chk("rst_accum.m_valid", mv[0], 0); end
    check_all("rst_accum", 1'b0);

    for (int w = 0; w < 20; w++) begin
      int len;
      bit early;
      len = $urandom_range(1, 6);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 7) == 0) rand_send(1'($urandom), 1'b1);
        rand_send(j == len - 1, 1'b0);
        if (j < len - 1) idle($urandom_range(0, 2));
      end
      early = 1'($urandom);
      wait_result(early);
      handshake(early ? 0 : $urandom_range(0, 4));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
